rgb_blink_sequencer: RTL
========================

RGB_BLINK_SEQUENCER -- requirements
Module: rgb_blink_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 12000000: clock cycles per colour step (minimum 2).
REQ-002 SHALL have parameter PWM_W, default 8: width of the PWM counter and of duty.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port en, input, 1 bit: run enable.
REQ-006 SHALL have port next, input, 1 bit: manual-advance request, sampled each cycle.
REQ-007 SHALL have port duty, input, PWM_W bits: brightness, on-time in PWM counts.
REQ-008 SHALL have port redled, output reg, 1 bit: red LED drive, active-low (0 = lit).
REQ-009 SHALL have port greenled, output reg, 1 bit: green LED drive, active-low.
REQ-010 SHALL have port blueled, output reg, 1 bit: blue LED drive, active-low.
REQ-011 SHALL have port colour, output, 3 bits: current state encoding.
REQ-012 SHALL have port step_pulse, output reg, 1 bit: one-cycle strobe on every state advance.

Function
REQ-013 SHALL implement states RED=0, GREEN=1, BLUE=2, WHITE=3, OFF=4; codes 5-7 unreachable and SHALL recover to RED on the next cycle.
REQ-014 SHALL advance RED->GREEN->BLUE->WHITE->OFF->RED, one step per advance event.
REQ-015 SHALL keep a prescaler counting 0..HOLD_CYCLES-1 while en=1, wrapping to 0; an advance event occurs in the cycle the prescaler equals HOLD_CYCLES-1.
REQ-016 SHALL treat next=1 with en=1 as an advance event; it SHALL also clear the prescaler to 0.
REQ-017 SHALL, when the prescaler terminal count and next coincide, advance exactly once and clear the prescaler to 0.
REQ-018 SHALL register step_pulse=1 in the cycle after each advance event; otherwise 0.
REQ-019 SHALL hold the prescaler, state and PWM counter, and ignore next, while en=0.
REQ-020 SHALL run a free-running PWM_W-bit counter pwm_cnt while en=1, wrapping from 2^PWM_W-1 to 0.
REQ-021 SHALL copy duty into an internal duty_q only when pwm_cnt wraps to 0; duty changes mid-period SHALL take effect at the next period.
REQ-022 SHALL define pwm_on = (pwm_cnt < duty_q); duty_q=0 SHALL give an always-dark LED; maximum duty SHALL give an on-time of 2^PWM_W-1 counts per period.
REQ-023 SHALL drive each LED low when en=1, pwm_on=1 and the LED is in the current colour set; otherwise high.
REQ-024 SHALL use these colour sets: RED={red}, GREEN={green}, BLUE={blue}, WHITE={red,green,blue}, OFF={}.
REQ-025 SHALL register LED outputs; each LED SHALL reflect state and pwm_cnt one cycle after they are sampled.
REQ-026 SHALL drive all LEDs high on the first clock edge after en falls.
REQ-027 SHALL drive colour combinationally from the state register.

Reset
REQ-028 SHALL, on a clk edge with rst=1, set state=RED, prescaler=0, pwm_cnt=0, duty_q=0, step_pulse=0, and redled=greenled=blueled=1.
REQ-029 SHALL give rst priority over en, next and the terminal count, including a reset mid-step.
REQ-030 SHALL, after reset, keep LEDs dark until the first PWM wrap loads a non-zero duty.

Verification (HOLD_CYCLES=4, PWM_W=3)
REQ-031 Reset then en=1, duty=7, held for 24 cycles -> colour sequence 0,1,2,3,4,0 with 4 cycles per step; step_pulse high for exactly 1 cycle per advance.
REQ-032 en=1, duty=4 in state RED -> redled low for 4 of every 8 cycles (pwm_cnt 0-3); greenled and blueled stay 1.
REQ-033 next pulsed while prescaler=1 -> advance to next colour on that edge; prescaler=0; next advance 4 cycles later.
REQ-034 next asserted in the cycle prescaler=3 -> exactly one advance; step_pulse high for 1 cycle only.
REQ-035 en dropped mid-step in state BLUE with prescaler=2 -> all LEDs 1 on the next edge; after 10 cycles en=1 -> state still BLUE, advance occurs after 2 more cycles.
REQ-036 rst asserted in state WHITE mid-PWM; duty changed 7->0 mid-period in a second run -> after rst: colour=0 and LEDs=1; after duty change: LEDs stay at the old duty until pwm_cnt wraps to 0, then stay 1.

Source files
------------

// File: rtl/rgb_blink_sequencer.sv
// Purpose: steps an RGB LED through RED/GREEN/BLUE/WHITE/OFF with PWM brightness.
// Latency: LED outputs and step_pulse are registered, 1 cycle after state/pwm_cnt/advance.
// Backpressure: none; en pauses everything, next forces an early step.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset
//   en         - run enable; low freezes prescaler, state and PWM and darkens the LEDs
//   next       - manual advance request (only honoured while en=1)
//   duty       - brightness (on-time in PWM counts), latched at each PWM period start
//   redled     - red drive, active-low
//   greenled   - green drive, active-low
//   blueled    - blue drive, active-low
//   colour     - current state code (RED=0 .. OFF=4)
//   step_pulse - one-cycle strobe following every advance
module rgb_blink_sequencer #(
   parameter int HOLD_CYCLES = 12000000,
   parameter int PWM_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             next,
   input  logic [PWM_W-1:0] duty,
   output logic             redled,
   output logic             greenled,
   output logic             blueled,
   output logic [2:0]       colour,
   output logic             step_pulse
);

   localparam int               PS_W     = $clog2(HOLD_CYCLES);
   localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(HOLD_CYCLES - 1);
   localparam logic [PWM_W-1:0] PWM_LAST = '1;

   typedef enum logic [2:0] {
      RED   = 3'd0,
      GREEN = 3'd1,
      BLUE  = 3'd2,
      WHITE = 3'd3,
      OFF   = 3'd4
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [PS_W-1:0]  presc;
   logic [PWM_W-1:0] pwm_cnt;
   logic [PWM_W-1:0] duty_q;
   logic             advance;
   logic             pwm_on;
   logic             lit_r;
   logic             lit_g;
   logic             lit_b;

   // Terminal count and a manual request coinciding still make a single
   // advance: both just feed the same OR.
   assign advance = en & ((presc == PS_LAST) | next);
   assign pwm_on  = (pwm_cnt < duty_q);
   assign colour  = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RED;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      lit_r     = 1'b0;
      lit_g     = 1'b0;
      lit_b     = 1'b0;
      case (state)
         RED: begin
            lit_r = 1'b1;
            if (advance) state_nxt = GREEN;
         end
         GREEN: begin
            lit_g = 1'b1;
            if (advance) state_nxt = BLUE;
         end
         BLUE: begin
            lit_b = 1'b1;
            if (advance) state_nxt = WHITE;
         end
         WHITE: begin
            lit_r = 1'b1;
            lit_g = 1'b1;
            lit_b = 1'b1;
            if (advance) state_nxt = OFF;
         end
         OFF: begin
            if (advance) state_nxt = RED;
         end
         // Codes 5-7 are unreachable; fall back to RED regardless of en.
         default: state_nxt = RED;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc      <= '0;
         pwm_cnt    <= '0;
         duty_q     <= '0;
         step_pulse <= 1'b0;
         redled     <= 1'b1;
         greenled   <= 1'b1;
         blueled    <= 1'b1;
      end else begin
         step_pulse <= advance;
         if (en) begin
            // A manual advance restarts the hold period from zero.
            presc   <= advance ? '0 : presc + 1'b1;
            pwm_cnt <= pwm_cnt + 1'b1;
            // Latch brightness on the wrap so a period is never cut short.
            if (pwm_cnt == PWM_LAST) begin
               duty_q <= duty;
            end
         end
         // en is part of the term so LEDs go dark on the first edge with en low.
         redled   <= ~(en & pwm_on & lit_r);
         greenled <= ~(en & pwm_on & lit_g);
         blueled  <= ~(en & pwm_on & lit_b);
      end
   end

endmodule
